// File: rtl/ni_request_payload_collector_pkg.sv
// Shared definitions for the NI request payload collector.
//   FTYPEWD        : width of the flit type field stripped before payload assembly
//   COUNTERFLITWD  : width of flit counters / payload flit counts
//   DEF_*          : default geometry (32-bit link, up to 3 payload flits, 90-bit payload)
//   state_t        : collector FSM states
package ni_request_payload_collector_pkg;

  localparam int unsigned FTYPEWD                  = 2;
  localparam int unsigned COUNTERFLITWD            = 4;
  localparam int unsigned DEF_FLIT_WIDTH           = 32;
  localparam int unsigned DEF_MAX_REQ_PAYLOADFLITS = 3;
  localparam int unsigned DEF_REQ_PAYLOADLENGTH    = 90;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_t;

endpackage

// File: rtl/ni_request_payload_collector.sv
// Reassembles BASE_WIDTH-bit payload flits into one wide request payload.
// Flit k of a packet lands in payload[BASE_WIDTH*k +: BASE_WIDTH]; the first
// flit of a packet clears all slots so short packets leave upper slots zero.
// The assembled payload is held until the consumer takes it.
//
// Ports:
//   clock           : system clock, rising edge
//   reset           : synchronous, active-high
//   flit_in         : payload flit data
//   flit_valid      : flit_in is valid
//   flit_last       : flit_in is the packet tail
//   flit_ready      : collector accepts a flit this cycle (depends on state only)
//   payload         : assembled payload
//   payload_valid   : payload complete and stable
//   payload_ready   : consumer takes the payload
//   payload_flits   : number of flits received for the held payload
//   payload_overrun : flit limit reached without a tail flit
module ni_request_payload_collector
  import ni_request_payload_collector_pkg::*;
#(
  parameter int unsigned FLIT_WIDTH           = DEF_FLIT_WIDTH,
  parameter int unsigned BASE_WIDTH           = FLIT_WIDTH - FTYPEWD,
  parameter int unsigned MAX_REQ_PAYLOADFLITS = DEF_MAX_REQ_PAYLOADFLITS,
  parameter int unsigned REQ_PAYLOADLENGTH    = DEF_REQ_PAYLOADLENGTH
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [BASE_WIDTH-1:0]        flit_in,
  input  logic                         flit_valid,
  input  logic                         flit_last,
  output logic                         flit_ready,
  output logic [REQ_PAYLOADLENGTH-1:0] payload,
  output logic                         payload_valid,
  input  logic                         payload_ready,
  output logic [COUNTERFLITWD-1:0]     payload_flits,
  output logic                         payload_overrun
);

  localparam int unsigned SLOT_BITS = BASE_WIDTH * MAX_REQ_PAYLOADFLITS;
  localparam logic [COUNTERFLITWD-1:0] LAST_SLOT = COUNTERFLITWD'(MAX_REQ_PAYLOADFLITS - 1);

  state_t                     state;
  state_t                     state_next;
  logic [COUNTERFLITWD-1:0]   flit_counter;
  logic [BASE_WIDTH-1:0]      slots [MAX_REQ_PAYLOADFLITS];
  logic [SLOT_BITS-1:0]       slot_flat;

  logic accept;
  logic at_limit;
  logic release_payload;

  assign at_limit        = (flit_counter == LAST_SLOT);
  assign accept          = flit_valid & flit_ready;
  assign release_payload = payload_valid & payload_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next state and flit_ready; flit_ready comes from the state register only
  always_comb begin
    state_next = state;
    flit_ready = 1'b0;
    case (state)
      COLLECT: begin
        flit_ready = 1'b1;
        if (flit_valid && (flit_last || at_limit)) begin
          state_next = HOLD;
        end
      end
      HOLD: begin
        if (payload_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Slot array, flit counter and payload status.
  // accept and release_payload are mutually exclusive: accept needs COLLECT,
  // release needs payload_valid, which is only set while in HOLD.
  always_ff @(posedge clock) begin
    if (reset) begin
      flit_counter    <= '0;
      payload_valid   <= 1'b0;
      payload_flits   <= '0;
      payload_overrun <= 1'b0;
      for (int unsigned i = 0; i < MAX_REQ_PAYLOADFLITS; i++) begin
        slots[i] <= '0;
      end
    end else if (accept) begin
      // First flit of a packet writes slot 0 and clears every other slot.
      for (int unsigned i = 0; i < MAX_REQ_PAYLOADFLITS; i++) begin
        if (flit_counter == COUNTERFLITWD'(i)) begin
          slots[i] <= flit_in;
        end else if (flit_counter == '0) begin
          slots[i] <= '0;
        end
      end
      payload_overrun <= at_limit & ~flit_last;
      if (flit_last || at_limit) begin
        payload_valid <= 1'b1;
        payload_flits <= flit_counter + 1'b1;
        flit_counter  <= '0;
      end else begin
        flit_counter <= flit_counter + 1'b1;
      end
    end else if (release_payload) begin
      payload_valid   <= 1'b0;
      payload_overrun <= 1'b0;
    end
  end

  always_comb begin
    slot_flat = '0;
    for (int unsigned i = 0; i < MAX_REQ_PAYLOADFLITS; i++) begin
      slot_flat[BASE_WIDTH*i +: BASE_WIDTH] = slots[i];
    end
  end

  // Map slot bits onto the payload: drop slot bits beyond the payload width,
  // or zero-fill payload bits that no slot covers.
  generate
    if (REQ_PAYLOADLENGTH < SLOT_BITS) begin : g_truncate
      logic unused_slot_bits;
      assign unused_slot_bits = ^slot_flat[SLOT_BITS-1:REQ_PAYLOADLENGTH];
      assign payload = slot_flat[REQ_PAYLOADLENGTH-1:0];
    end else if (REQ_PAYLOADLENGTH > SLOT_BITS) begin : g_extend
      assign payload = {{(REQ_PAYLOADLENGTH - SLOT_BITS){1'b0}}, slot_flat};
    end else begin : g_exact
      assign payload = slot_flat;
    end
  endgenerate

endmodule

// File: tb/tb_ni_request_payload_collector.sv
module tb_ni_request_payload_collector;

  localparam int BW = 30;
  localparam int PL = 90;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [BW-1:0] flit_in = '0;
  logic          flit_valid = 1'b0;
  logic          flit_last = 1'b0;
  logic          flit_ready;
  logic [PL-1:0] payload;
  logic          payload_valid;
  logic          payload_ready = 1'b0;
  logic [CW-1:0] payload_flits;
  logic          payload_overrun;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [PL-1:0] data;
    int            flits;
    logic          ovr;
  } exp_t;

  exp_t sb[$];

  ni_request_payload_collector #(
    .FLIT_WIDTH(32),
    .MAX_REQ_PAYLOADFLITS(3),
    .REQ_PAYLOADLENGTH(90)
  ) dut (
    .clock(clock),
    .reset(reset),
    .flit_in(flit_in),
    .flit_valid(flit_valid),
    .flit_last(flit_last),
    .flit_ready(flit_ready),
    .payload(payload),
    .payload_valid(payload_valid),
    .payload_ready(payload_ready),
    .payload_flits(payload_flits),
    .payload_overrun(payload_overrun)
  );

  always #5 clock = ~clock;

  // Expected payload: flit k occupies bits [30k +: 30], unused slots zero.
  function automatic exp_t make_exp(input logic [BW-1:0] f0, input logic [BW-1:0] f1,
                                    input logic [BW-1:0] f2, input int n, input logic ovr);
    exp_t e;
    e.data = '0;
    if (n > 0) e.data[BW-1:0]      = f0;
    if (n > 1) e.data[2*BW-1:BW]   = f1;
    if (n > 2) e.data[3*BW-1:2*BW] = f2;
    e.flits = n;
    e.ovr   = ovr;
    return e;
  endfunction

  // All tasks start and end at posedge + 1.
  task automatic send_flit(input logic [BW-1:0] d, input logic last);
    bit ok;
    ok = 1'b0;
    flit_in    = d;
    flit_last  = last;
    flit_valid = 1'b1;
    for (int c = 0; c < 50; c++) begin
      if (flit_ready === 1'b1) begin
        @(posedge clock); #1;
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    flit_valid = 1'b0;
    flit_last  = 1'b0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL flit_accept_timeout: flit %h not accepted within 50 cycles", d);
    end
  endtask

  task automatic wait_valid(input string name, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 50; c++) begin
      if (payload_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(posedge clock); #1;
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL %s_valid_timeout: payload_valid not seen within 50 cycles", name);
    end
  endtask

  task automatic check_payload(input string name);
    bit   ok;
    exp_t e;
    wait_valid(name, ok);
    if (!ok) return;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s_sb_empty: payload produced with no expected entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (payload !== e.data) begin
      errors++;
      $display("FAIL %s_data: got %h expected %h", name, payload, e.data);
    end
    checks++;
    if (payload_flits !== CW'(e.flits)) begin
      errors++;
      $display("FAIL %s_flits: got %0d expected %0d", name, payload_flits, e.flits);
    end
    checks++;
    if (payload_overrun !== e.ovr) begin
      errors++;
      $display("FAIL %s_overrun: got %b expected %b", name, payload_overrun, e.ovr);
    end
  endtask

  task automatic release_payload();
    payload_ready = 1'b1;
    @(posedge clock); #1;
    payload_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    checks++;
    if (payload !== '0 || payload_valid !== 1'b0 || payload_flits !== '0 ||
        payload_overrun !== 1'b0 || flit_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: payload=%h valid=%b flits=%0d ovr=%b ready=%b expected 0/0/0/0/1",
               payload, payload_valid, payload_flits, payload_overrun, flit_ready);
    end
  endtask

  task automatic test_full_packet();
    logic [PL-1:0] held;
    sb.push_back(make_exp(30'h0AAAAAAA, 30'h15555555, 30'h3FFFFFFF, 3, 1'b0));
    send_flit(30'h0AAAAAAA, 1'b0);
    send_flit(30'h15555555, 1'b0);
    checks++;
    if (payload_valid !== 1'b0) begin
      errors++;
      $display("FAIL full_early_valid: got %b expected 0 before tail", payload_valid);
    end
    send_flit(30'h3FFFFFFF, 1'b1);
    checks++;
    if (payload_valid !== 1'b1) begin
      errors++;
      $display("FAIL full_latency: payload_valid got %b expected 1 one cycle after tail", payload_valid);
    end
    check_payload("full");
    held = payload;
    release_payload();
    checks++;
    if (payload_valid !== 1'b0 || payload !== held) begin
      errors++;
      $display("FAIL full_release: valid=%b payload=%h expected 0 and %h retained",
               payload_valid, payload, held);
    end
  endtask

  task automatic test_short_packet();
    sb.push_back(make_exp(30'h0012345, '0, '0, 1, 1'b0));
    send_flit(30'h0012345, 1'b1);
    check_payload("short");
    release_payload();
  endtask

  task automatic test_backpressure();
    logic [PL-1:0] held;
    sb.push_back(make_exp(30'h1, 30'h2, 30'h3, 3, 1'b0));
    send_flit(30'h1, 1'b0);
    send_flit(30'h2, 1'b0);
    send_flit(30'h3, 1'b1);
    held = payload;
    flit_in    = 30'h0BEEF;
    flit_last  = 1'b1;
    flit_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      checks++;
      if (flit_ready !== 1'b0 || payload_valid !== 1'b1 || payload !== held) begin
        errors++;
        $display("FAIL bp_hold_%0d: ready=%b valid=%b payload=%h expected 0/1/%h",
                 c, flit_ready, payload_valid, payload, held);
      end
      @(posedge clock); #1;
    end
    check_payload("bp");
    release_payload();
    checks++;
    if (flit_ready !== 1'b1 || payload_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_bubble: ready=%b valid=%b expected 1/0 after release",
               flit_ready, payload_valid);
    end
    sb.push_back(make_exp(30'h0BEEF, '0, '0, 1, 1'b0));
    @(posedge clock); #1;
    flit_valid = 1'b0;
    flit_last  = 1'b0;
    checks++;
    if (payload_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_next_accept: payload_valid got %b expected 1 one cycle after release",
               payload_valid);
    end
    check_payload("bp_next");
    release_payload();
  endtask

  task automatic test_overrun();
    sb.push_back(make_exp(30'h11, 30'h22, 30'h33, 3, 1'b1));
    send_flit(30'h11, 1'b0);
    send_flit(30'h22, 1'b0);
    send_flit(30'h33, 1'b0);
    check_payload("overrun");
    release_payload();
    sb.push_back(make_exp(30'h44, '0, '0, 1, 1'b0));
    send_flit(30'h44, 1'b1);
    check_payload("after_overrun");
    release_payload();
  endtask

  task automatic test_reset_mid_packet();
    send_flit(30'h2AAAA, 1'b0);
    send_flit(30'h15555, 1'b0);
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++;
    if (payload_valid !== 1'b0 || payload !== '0) begin
      errors++;
      $display("FAIL midreset_clear: valid=%b payload=%h expected 0/0", payload_valid, payload);
    end
    sb.push_back(make_exp(30'h7, '0, '0, 1, 1'b0));
    send_flit(30'h7, 1'b1);
    check_payload("midreset");
    release_payload();
  endtask

  task automatic test_random();
    fork
      begin : producer
        for (int p = 0; p < 1000; p++) begin
          logic [BW-1:0] f [3];
          int   n;
          logic ovr;
          n   = $urandom_range(1, 3);
          ovr = (n == 3) && ($urandom_range(0, 7) == 0);
          for (int k = 0; k < 3; k++) f[k] = BW'($urandom);
          sb.push_back(make_exp(f[0], f[1], f[2], n, ovr));
          for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, 2)) begin
              @(posedge clock); #1;
            end
            send_flit(f[k], (k == n - 1) && !ovr);
          end
        end
      end
      begin : consumer
        for (int p = 0; p < 1000; p++) begin
          bit   ok;
          exp_t e;
          wait_valid("rand", ok);
          if (ok) begin
            checks++;
            if (sb.size() == 0) begin
              errors++;
              $display("FAIL rand_sb_empty_%0d: payload produced with no expected entry", p);
            end else begin
              e = sb.pop_front();
              if (payload !== e.data || payload_flits !== CW'(e.flits) || payload_overrun !== e.ovr) begin
                errors++;
                $display("FAIL rand_pkt_%0d: got %h/%0d/%b expected %h/%0d/%b", p,
                         payload, payload_flits, payload_overrun, e.data, e.flits, e.ovr);
              end
            end
          end
          repeat ($urandom_range(0, 3)) begin
            @(posedge clock); #1;
          end
          release_payload();
        end
      end
    join
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rand_leftover: %0d expected payloads never produced, expected 0", sb.size());
    end
  endtask

  initial begin
    @(posedge clock); #1;
    test_reset();
    test_full_packet();
    test_short_packet();
    test_backpressure();
    test_overrun();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
